// File: rtl/instruction_memory_fetch.sv
// Programmable instruction store with a valid/ready fetch port.
// Load port writes words; each accepted fetch returns one word a cycle later.
module instruction_memory_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_ADDR = 0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    output logic                  fetch_ready,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  flush,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_fault,
    input  logic                  prog_en,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_err
);

    localparam int SHIFT = (BYTE_ADDR != 0) ? $clog2(DATA_WIDTH / 8) : 0;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0] instr_addr_q, instr_addr_d;
    logic                  instr_fault_q, instr_fault_d;
    logic                  prog_err_q, prog_err_d;

    logic [ADDR_WIDTH-1:0] f_idx, p_idx;
    logic                  f_in_range, p_in_range;
    logic                  accept, prog_wr;

    // Index math stays at full address width so large addresses never alias.
    assign f_idx      = fetch_addr >> SHIFT;
    assign p_idx      = prog_addr >> SHIFT;
    assign f_in_range = f_idx < DEPTH_A;
    assign p_in_range = p_idx < DEPTH_A;

    assign fetch_ready = rst && !prog_en
                         && (!instr_valid_q || instr_ready || flush);
    assign accept  = fetch_valid && fetch_ready;
    assign prog_wr = prog_en && prog_we && p_in_range;

    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_addr_d  = instr_addr_q;
        instr_fault_d = instr_fault_q;
        prog_err_d    = prog_en && prog_we && !p_in_range;
        if (accept) begin
            instr_valid_d = 1'b1;
            instr_addr_d  = fetch_addr;
            instr_fault_d = !f_in_range;
            instr_data_d  = f_in_range ? mem_q[f_idx[IW-1:0]] : NOP_WORD;
        end else if (instr_valid_q && (instr_ready || flush)) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_addr_q  <= '0;
            instr_fault_q <= 1'b0;
            prog_err_q    <= 1'b0;
        end else begin
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_addr_q  <= instr_addr_d;
            instr_fault_q <= instr_fault_d;
            prog_err_q    <= prog_err_d;
        end
    end

    // Program contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (prog_wr) begin
            mem_q[p_idx[IW-1:0]] <= prog_data;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_addr  = instr_addr_q;
    assign instr_fault = instr_fault_q;
    assign prog_err    = prog_err_q;

endmodule

// File: doc/instruction_memory_fetch.md
Name: instruction_memory_fetch

Overview:
Parametrised, programmable instruction memory with a valid/ready fetch interface, the next generation of the CPU's instruction store. Program contents are written through a dedicated load port instead of being hard-coded on reset. Each fetch returns one word one cycle later, holds it under back-pressure, and flags out-of-range addresses. It sits between the PC/fetch stage and decode, and supports flushing for jumps and branches.

Parameters:
DATA_WIDTH, 32, instruction word width in bits; must be a multiple of 8.
DEPTH, 64, number of words stored.
ADDR_WIDTH, 32, width of fetch and program address buses.
BYTE_ADDR, 0, 0 = addresses are word indices; 1 = addresses are byte addresses, index = addr >> log2(DATA_WIDTH/8), low bits ignored.
NOP_WORD, 32'h0, word driven on instr_data for a faulting fetch.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
fetch_valid  in  1  fetch request present.
fetch_ready  out  1  fetch request accepted this cycle when high together with fetch_valid.
fetch_addr  in  ADDR_WIDTH  fetch address.
flush  in  1  discard the held output word (branch/jump taken).
instr_valid  out  1  instr_data/instr_addr/instr_fault are valid.
instr_ready  in  1  consumer takes the output word.
instr_data  out  DATA_WIDTH  fetched instruction.
instr_addr  out  ADDR_WIDTH  echo of the accepted fetch_addr.
instr_fault  out  1  fetched address was out of range.
prog_en  in  1  program mode; blocks fetches.
prog_we  in  1  write strobe, honoured only while prog_en=1.
prog_addr  in  ADDR_WIDTH  write address, same addressing mode as fetch.
prog_data  in  DATA_WIDTH  write data.
prog_err  out  1  one-cycle pulse on an out-of-range write.

Behaviour:
- Reset (rst=0, asynchronous): instr_valid=0, instr_data=0, instr_addr=0, instr_fault=0, prog_err=0. Memory array is NOT cleared and keeps its contents across reset.
- fetch_ready = rst && !prog_en && (!instr_valid || instr_ready || flush). This is combinational and has no dependency on fetch_valid.
- Accept (fetch_valid && fetch_ready): on the next edge the block sets instr_valid=1, instr_addr=fetch_addr, and instr_data=mem[index]. Latency is exactly 1 cycle. Back-to-back accepts give one word per cycle.
- Fault: index >= DEPTH gives instr_fault=1 and instr_data=NOP_WORD. The memory is not read.
- Hold: instr_valid && !instr_ready && !flush keeps all outputs stable.
- Consume without new accept: instr_valid && instr_ready with no accept clears instr_valid to 0. Data outputs keep their last value.
- Flush: drops the held word.
  - flush with no accept: instr_valid=0 next cycle.
  - flush with an accept in the same cycle: the new word is loaded and the old word is lost.
  - flush while prog_en=1: instr_valid=0 next cycle.
- Program write: prog_en && prog_we && index < DEPTH writes mem[index]=prog_data at the edge.
  - Out-of-range write: ignored, and prog_err=1 for one cycle.
  - prog_we with prog_en=0: ignored, no error.
- prog_en assertion:
  - Fetches stop being accepted in the same cycle.
  - A word already held stays valid until it is consumed or flushed.
  - Fetches resume the cycle prog_en drops.
- Reset mid-operation: outputs clear immediately, and any in-flight word is lost. The first fetch can be accepted in the first cycle with rst=1.
- Index arithmetic is done at ADDR_WIDTH width. Addresses do not wrap modulo DEPTH.

Test Plan:
- Load then fetch: prog_en=1, write mem[0..2]=32'h3C01003F, 32'h3C020043, 32'h3C030020. Then prog_en=0 and fetch addr 0,1,2 back-to-back with instr_ready=1. Expect instr_valid high for 3 consecutive cycles, each 1 cycle after accept, with the data in order and instr_addr = 0,1,2.
- Back-pressure: fetch addr 1 then addr 2 while instr_ready=0 for 3 cycles. Expect instr_data held at 32'h3C020043 and fetch_ready=0. Raise instr_ready: addr 2 is accepted and 32'h3C030020 appears next cycle.
- Fault: fetch addr 64 (DEPTH=64). Expect instr_fault=1 and instr_data=32'h0. Program write to addr 70: prog_err pulses once and mem[6] is unchanged.
- Byte mode (BYTE_ADDR=1): write prog_addr 8, then fetch addr 8 and addr 11. Both return the same word; fetch addr 256 faults.
- Flush: hold the word at addr 1 with instr_ready=0, then assert flush while fetching addr 2. Expect addr 2's word next cycle and addr 1's word never consumed. Flush alone gives instr_valid=0.
- Reset mid-stream: drive rst=0 between edges while instr_valid=1. Outputs go to 0 immediately. After release, fetch addr 0 returns the previously loaded 32'h3C01003F.
